mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Byte-serial memory controller between the pipeline and the 8-bit RAM/IO bus.
//  Arbitrates the instruction-fetch port (IF) and the load/store port (MEM);
//  turns 1/2/4-byte requests into little-endian byte sequences on the bus.
//  Drives the CPU's external mem_a/mem_dout/mem_wr and samples mem_din.
// PARAMETERS
//  ADDR_W        32  request address width
//  BUS_ADDR_BITS 18  low bits driven on ram_a_out; upper bits forced 0
// PORTS
//  clk_in        in   1   system clock
//  rst_in        in   1   synchronous reset, active-high
//  rdy_in        in   1   pause when low
//  if_req_in     in   1   fetch request, held until done
//  if_addr_in    in   32  fetch address (4-byte read)
//  if_done_out   out  1   one-cycle pulse, fetch complete
//  if_inst_out   out  32  fetched word, valid when if_done_out
//  mem_req_in    in   1   load/store request, held until done
//  mem_wr_in     in   1   1 = store, 0 = load
//  mem_addr_in   in   32  load/store address
//  mem_len_in    in   2   0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes (2 illegal)
//  mem_wdata_in  in   32  store data, low bytes used
//  mem_done_out  out  1   one-cycle pulse, load/store complete
//  mem_rdata_out out  32  load data, zero-extended, valid when mem_done_out
//  ram_din_in    in   8   bus read data (valid the cycle after its address)
//  ram_dout_out  out  8   bus write data
//  ram_a_out     out  32  bus address
//  ram_wr_out    out  1   1 = write this cycle
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, DONE. Reset: all outputs 0, state IDLE.
//  - IDLE: bus idle (ram_a_out=0, ram_wr_out=0, ram_dout_out=0). Requests are
//    sampled only in IDLE; mem_req_in beats if_req_in when both are high.
//  - N = byte count. Byte i uses address A+i, data bits [8i+7:8i].
//  - Read, request seen in cycle 0: ram_a_out=A+i in cycle 1+i; ram_din_in is
//    captured in cycle 2+i; DONE in cycle N+2 (word fetch: done in cycle 6).
//  - Write: ram_a_out=A+i, ram_dout_out=byte i, ram_wr_out=1 in cycle 1+i;
//    DONE in cycle N+1. Each byte is written exactly once (IO 0x30000 safe).
//  - DONE: the requesting port's done pulses 1 cycle with data; then IDLE.
//    The requester drops req on the edge after done; req high in IDLE = new.
//  - if_inst_out/mem_rdata_out hold the last value between completions.
//  - rdy_in low: no state/counter/data change; ram_wr_out forced 0; done
//    held off. A read byte whose capture cycle is paused is re-addressed
//    after resume. Writes resume at the unwritten byte.
//  - rst_in mid-operation: request abandoned, no done pulse, IDLE next cycle.
//  - mem_len_in=2: treated as 1 byte. Address A+i wraps modulo 2^ADDR_W.
// CONFIGURATION
//  MEM_CTRL_IFBUF_EN defined: one-entry fetch buffer {valid, addr, word}
//  - Filled on every completed fetch. An IF request in IDLE with no
//    mem_req_in and if_addr_in == buffered addr enters DONE directly:
//    if_done_out in cycle 1, no bus activity.
//  - Invalidated by reset and by any store that writes a byte inside the
//    buffered word (addr[31:2] match on any written byte).
//  Undefined: no buffer; every fetch goes to the bus with the timing above.
// TESTING
//  - Word fetch at 0x0000_0010, RAM bytes 13 05 00 00 -> ram_a 0x10..0x13
//    in cycles 1-4, if_done_out in cycle 6, if_inst_out=0x0000_0513.
//  - Store word 0xDEADBEEF at 0x100 -> writes EF,BE,AD,DE to 0x100..0x103
//    in cycles 1-4, mem_done_out in cycle 5; byte load at 0x102 -> 0x0000_00AD.
//  - if_req_in and mem_req_in both rising in the same IDLE cycle -> MEM served
//    first, fetch starts the cycle after mem_done_out's DONE cycle.
//  - Byte store 0x41 to 0x30000 with rdy_in low cycles 1-3 -> exactly one
//    ram_wr_out pulse, at cycle 4, with ram_a_out=0x30000, ram_dout_out=0x41.
//  - rst_in asserted in cycle 3 of a word load -> no mem_done_out, all
//    outputs 0 the next cycle, a new request then completes normally.
//  - MEM_CTRL_IFBUF_EN: repeat fetch of 0x10 -> if_done_out in cycle 1, no bus
//    activity. Store byte to 0x11, then fetch 0x10 -> full 6-cycle bus fetch.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch (IF) and load/store (MEM) requests onto a byte-serial 8-bit RAM/IO bus.
// Optional one-entry fetch buffer is built when MEM_CTRL_IFBUF_EN is defined.
//  state | meaning
//  IDLE  | bus idle, sample requests (MEM wins over IF)
//  READ  | issue byte addresses, capture ram_din_in one cycle later
//  WRITE | one bus write per byte, little-endian order
//  DONE  | pulse the requester's done with data, then IDLE
module mem_ctrl #(
   parameter int ADDR_W        = 32,
   parameter int BUS_ADDR_BITS = 18
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_done_out,
   output logic [31:0]       if_inst_out,
   input  logic              mem_req_in,
   input  logic              mem_wr_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [1:0]        mem_len_in,
   input  logic [31:0]       mem_wdata_in,
   output logic              mem_done_out,
   output logic [31:0]       mem_rdata_out,
   input  logic [7:0]        ram_din_in,
   output logic [7:0]        ram_dout_out,
   output logic [ADDR_W-1:0] ram_a_out,
   output logic              ram_wr_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] BUS_MASK = ADDR_W'((64'd1 << BUS_ADDR_BITS) - 64'd1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       if_inst_q, if_inst_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic [2:0]        n_q, n_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              is_if_q, is_if_d;
   logic              wr_q, wr_d;
   logic              redo_q, redo_d;

   logic              buf_hit;
   logic [31:0]       buf_word;
   logic [2:0]        req_n;
   logic [2:0]        byte_idx;
   logic [1:0]        cap_idx;
   logic [ADDR_W-1:0] byte_addr;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      data_d       = data_q;
      if_inst_d    = if_inst_q;
      mem_rdata_d  = mem_rdata_q;
      n_d          = n_q;
      cnt_d        = cnt_q;
      is_if_d      = is_if_q;
      wr_d         = wr_q;
      redo_d       = redo_q;
      if_done_out  = 1'b0;
      mem_done_out = 1'b0;
      ram_a_out    = '0;
      ram_dout_out = 8'd0;
      ram_wr_out   = 1'b0;

      case (mem_len_in)
         2'd1:    req_n = 3'd2;
         2'd3:    req_n = 3'd4;
         default: req_n = 3'd1;
      endcase
      // redo re-addresses the byte whose capture cycle was lost to a pause
      byte_idx  = redo_q ? (cnt_q - 3'd1) : cnt_q;
      byte_addr = addr_q + ADDR_W'(byte_idx);
      cap_idx   = cnt_q[1:0] - 2'd1;

      case (state_q)
         IDLE: begin
            if (rdy_in) begin
               if (mem_req_in) begin
                  addr_d  = mem_addr_in;
                  wdata_d = mem_wdata_in;
                  n_d     = req_n;
                  is_if_d = 1'b0;
                  wr_d    = mem_wr_in;
                  cnt_d   = 3'd0;
                  redo_d  = 1'b0;
                  data_d  = '0;
                  state_d = mem_wr_in ? WRITE : READ;
               end else if (if_req_in) begin
                  addr_d  = if_addr_in;
                  n_d     = 3'd4;
                  is_if_d = 1'b1;
                  wr_d    = 1'b0;
                  cnt_d   = 3'd0;
                  redo_d  = 1'b0;
                  data_d  = buf_hit ? buf_word : 32'd0;
                  state_d = buf_hit ? DONE : READ;
               end
            end
         end
         READ: begin
            if (redo_q || (cnt_q != n_q)) ram_a_out = byte_addr & BUS_MASK;
            if (!rdy_in) begin
               if (cnt_q != 3'd0) redo_d = 1'b1;
            end else if (redo_q) begin
               redo_d = 1'b0;
            end else begin
               if (cnt_q != 3'd0) data_d = data_q | ({24'd0, ram_din_in} << {cap_idx, 3'b000});
               if (cnt_q == n_q) state_d = DONE;
               else cnt_d = cnt_q + 3'd1;
            end
         end
         WRITE: begin
            ram_a_out    = byte_addr & BUS_MASK;
            ram_dout_out = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
            if (rdy_in) begin
               ram_wr_out = 1'b1;
               if (cnt_q == (n_q - 3'd1)) state_d = DONE;
               else cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            if (rdy_in) begin
               state_d = IDLE;
               if (is_if_q) begin
                  if_done_out = 1'b1;
                  if_inst_d   = data_q;
               end else begin
                  mem_done_out = 1'b1;
                  if (!wr_q) mem_rdata_d = data_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_inst_out   = if_done_out ? data_q : if_inst_q;
   assign mem_rdata_out = (mem_done_out && !wr_q) ? data_q : mem_rdata_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         n_q         <= 3'd0;
         cnt_q       <= 3'd0;
         is_if_q     <= 1'b0;
         wr_q        <= 1'b0;
         redo_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         data_q      <= data_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         is_if_q     <= is_if_d;
         wr_q        <= wr_d;
         redo_q      <= redo_d;
      end
   end

`ifdef MEM_CTRL_IFBUF_EN
   logic              buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]       buf_word_q, buf_word_d;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_word_d  = buf_word_q;
      if (state_q == DONE && rdy_in && is_if_q) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = addr_q;
         buf_word_d  = data_q;
      end
      // any written byte inside the buffered word makes it stale
      if (state_q == WRITE && rdy_in && (byte_addr[ADDR_W-1:2] == buf_addr_q[ADDR_W-1:2]))
         buf_valid_d = 1'b0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_word_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_word_q  <= buf_word_d;
      end
   end

   assign buf_hit  = buf_valid_q && (if_addr_in == buf_addr_q) && !mem_req_in;
   assign buf_word = buf_word_q;
`else
   assign buf_hit  = 1'b0;
   assign buf_word = 32'd0;
`endif

endmodule
